// File: rtl/sm_hex_display.sv
// Multiplexed seven-segment driver: scans the 32-bit snapshot out as hex digits,
// reloading the snapshot only on frame boundaries so a scan never tears.
module sm_hex_display #(
    parameter int DIGITS     = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int DEAD       = 1,
    parameter int BLANK_LZ   = 1,
    parameter int ACTIVE_LOW = 1
) (
    input  logic              clkIn,
    input  logic              rst,
    input  logic [31:0]       number,
    input  logic              hold,
    output logic [DIGITS-1:0] anodes,
    output logic [6:0]        segments
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{ACTIVE_LOW != 0}};
    localparam logic [6:0]        SEG_OFF  = {7{ACTIVE_LOW != 0}};

    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [31:0]       snap_reg, snap_next;
    logic              pend_reg, pend_next;
    logic [DIGITS-1:0] anodes_reg, anodes_next;
    logic [6:0]        segments_reg, segments_next;

    logic              cnt_wrap;
    logic              frame_end;
    logic              in_dead;
    logic              blank;
    logic              show;
    logic [3:0]        nibble;
    logic [6:0]        seg_code;
    logic [DIGITS-1:0] digit_sel;
    logic [DIGITS-1:0] digit_blank;
    logic [3:0]        nib [DIGITS];

    assign cnt_wrap  = (cnt_reg == CNT_LAST);
    assign frame_end = cnt_wrap && (idx_reg == IDX_LAST);

    // Per-digit select, nibble and leading-zero status
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign digit_sel[gi] = (idx_reg == IDX_W'(gi));
        assign nib[gi]       = snap_reg[4*gi +: 4];
        if (gi == 0 || BLANK_LZ == 0) begin : g_noblank
            assign digit_blank[gi] = 1'b0;
        end else begin : g_blank
            assign digit_blank[gi] = ~|snap_reg[4*DIGITS-1:4*gi];
        end
    end

    if (DEAD == 0) begin : g_no_dead
        assign in_dead = 1'b0;
    end else begin : g_dead
        assign in_dead = (cnt_reg < CNT_W'(DEAD));
    end

    assign blank = |(digit_sel & digit_blank);
    assign show  = !in_dead && !blank;

    always_comb begin
        nibble = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_sel[i]) begin
                nibble = nib[i];
            end
        end
    end

    // Active-high segment pattern, bit order {g,f,e,d,c,b,a}
    always_comb begin
        seg_code = 7'b0000000;
        case (nibble)
            4'h0: seg_code = 7'b0111111;
            4'h1: seg_code = 7'b0000110;
            4'h2: seg_code = 7'b1011011;
            4'h3: seg_code = 7'b1001111;
            4'h4: seg_code = 7'b1100110;
            4'h5: seg_code = 7'b1101101;
            4'h6: seg_code = 7'b1111101;
            4'h7: seg_code = 7'b0000111;
            4'h8: seg_code = 7'b1111111;
            4'h9: seg_code = 7'b1101111;
            4'hA: seg_code = 7'b1110111;
            4'hB: seg_code = 7'b1111100;
            4'hC: seg_code = 7'b0111001;
            4'hD: seg_code = 7'b1011110;
            4'hE: seg_code = 7'b1111001;
            4'hF: seg_code = 7'b1110001;
            default: seg_code = 7'b0000000;
        endcase
    end

    always_comb begin
        cnt_next      = cnt_wrap ? '0 : cnt_reg + 1'b1;
        idx_next      = idx_reg;
        snap_next     = snap_reg;
        pend_next     = pend_reg;
        anodes_next   = (show ? digit_sel : '0) ^ AN_OFF;
        segments_next = (show ? seg_code : 7'b0000000) ^ SEG_OFF;

        if (cnt_wrap) begin
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end

        // A pending load (after reset) ignores hold; otherwise reload only between frames
        if (pend_reg) begin
            snap_next = number;
            pend_next = 1'b0;
        end else if (frame_end && !hold) begin
            snap_next = number;
        end
    end

    always_ff @(posedge clkIn) begin
        if (rst) begin
            cnt_reg      <= '0;
            idx_reg      <= '0;
            snap_reg     <= '0;
            pend_reg     <= 1'b1;
            anodes_reg   <= AN_OFF;
            segments_reg <= SEG_OFF;
        end else begin
            cnt_reg      <= cnt_next;
            idx_reg      <= idx_next;
            snap_reg     <= snap_next;
            pend_reg     <= pend_next;
            anodes_reg   <= anodes_next;
            segments_reg <= segments_next;
        end
    end

    assign anodes   = anodes_reg;
    assign segments = segments_reg;

endmodule

// File: tb/tb_sm_hex_display.sv
// Directed bench for sm_hex_display with a 4-cycle slot and 1-cycle dead time,
// so one frame is 32 cycles; k counts edges since reset release (k=0 is the first).
module tb_sm_hex_display;

    logic        clkIn;
    logic        rst;
    logic [31:0] number;
    logic        hold;
    logic [7:0]  anodes;
    logic [6:0]  segments;

    int errors = 0;
    int checks = 0;
    int k      = 0;

    sm_hex_display #(
        .DIGITS    (8),
        .SCAN_DIV  (4),
        .DEAD      (1),
        .BLANK_LZ  (1),
        .ACTIVE_LOW(1)
    ) dut (
        .clkIn   (clkIn),
        .rst     (rst),
        .number  (number),
        .hold    (hold),
        .anodes  (anodes),
        .segments(segments)
    );

    initial clkIn = 1'b0;
    always #5 clkIn = ~clkIn;

    typedef struct {
        logic [31:0] num;
        int          digit;
        logic [7:0]  an;
        logic [6:0]  seg;
    } vec_t;

    vec_t vecs[23];

    task automatic chk(input string name, input logic [7:0] ea, input logic [6:0] es);
        checks++;
        if (anodes !== ea || segments !== es) begin
            errors++;
            $display("FAIL %s k=%0d: anodes=%h segments=%h, expected anodes=%h segments=%h",
                     name, k, anodes, segments, ea, es);
        end else begin
            $display("ok   %s k=%0d: anodes=%h segments=%h", name, k, anodes, segments);
        end
    endtask

    task automatic step();
        @(posedge clkIn);
        #1;
        k++;
    endtask

    task automatic step_to(input int target);
        while (k < target) step();
    endtask

    // Three reset edges with outputs checked, then release; next step() is k=0
    task automatic reset_with(input logic [31:0] n);
        rst    = 1'b1;
        number = n;
        hold   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clkIn);
            #1;
            chk("reset", 8'hFF, 7'h7F);
        end
        rst = 1'b0;
        k   = -1;
    endtask

    initial begin
        rst    = 1'b1;
        number = 32'h0;
        hold   = 1'b0;

        vecs[0]  = '{32'h1234ABCD, 0, 8'hFE, 7'h21};
        vecs[1]  = '{32'h1234ABCD, 1, 8'hFD, 7'h46};
        vecs[2]  = '{32'h1234ABCD, 2, 8'hFB, 7'h03};
        vecs[3]  = '{32'h1234ABCD, 3, 8'hF7, 7'h08};
        vecs[4]  = '{32'h1234ABCD, 4, 8'hEF, 7'h19};
        vecs[5]  = '{32'h1234ABCD, 5, 8'hDF, 7'h30};
        vecs[6]  = '{32'h1234ABCD, 6, 8'hBF, 7'h24};
        vecs[7]  = '{32'h1234ABCD, 7, 8'h7F, 7'h79};
        vecs[8]  = '{32'h000000A5, 0, 8'hFE, 7'h12};
        vecs[9]  = '{32'h000000A5, 1, 8'hFD, 7'h08};
        vecs[10] = '{32'h000000A5, 2, 8'hFF, 7'h7F};
        vecs[11] = '{32'h000000A5, 7, 8'hFF, 7'h7F};
        vecs[12] = '{32'h00000000, 0, 8'hFE, 7'h40};
        vecs[13] = '{32'h00000000, 1, 8'hFF, 7'h7F};
        vecs[14] = '{32'h9876E0F0, 1, 8'hFD, 7'h0E};
        vecs[15] = '{32'h9876E0F0, 2, 8'hFB, 7'h40};
        vecs[16] = '{32'h9876E0F0, 3, 8'hF7, 7'h06};
        vecs[17] = '{32'h9876E0F0, 4, 8'hEF, 7'h02};
        vecs[18] = '{32'h9876E0F0, 5, 8'hDF, 7'h78};
        vecs[19] = '{32'h9876E0F0, 6, 8'hBF, 7'h00};
        vecs[20] = '{32'h9876E0F0, 7, 8'h7F, 7'h10};
        vecs[21] = '{32'h00500000, 3, 8'hF7, 7'h40};
        vecs[22] = '{32'h00500000, 6, 8'hFF, 7'h7F};

        // Table: dead cycle then an active cycle of the chosen digit slot
        for (int v = 0; v < 23; v++) begin
            reset_with(vecs[v].num);
            step_to(4 * vecs[v].digit);
            chk("vec_dead", 8'hFF, 7'h7F);
            step_to(4 * vecs[v].digit + 2);
            chk("vec_digit", vecs[v].an, vecs[v].seg);
        end

        // Free run: full digit 0 slot, then repeat in the next frame
        reset_with(32'h1234ABCD);
        step_to(0);  chk("run_k0_dead", 8'hFF, 7'h7F);
        step_to(1);  chk("run_k1", 8'hFE, 7'h21);
        step_to(2);  chk("run_k2", 8'hFE, 7'h21);
        step_to(3);  chk("run_k3", 8'hFE, 7'h21);
        step_to(4);  chk("run_k4_dead", 8'hFF, 7'h7F);
        step_to(31); chk("run_d7_end", 8'h7F, 7'h79);
        step_to(32); chk("run_f2_dead", 8'hFF, 7'h7F);
        step_to(33); chk("run_f2_d0", 8'hFE, 7'h21);
        step_to(61); chk("run_f2_d7", 8'h7F, 7'h79);

        // Hold freezes the snapshot across two frame boundaries
        reset_with(32'h11111111);
        step_to(10);
        hold   = 1'b1;
        number = 32'h22222222;
        while (k < 75) begin
            step();
            if ((k % 4) == 0) chk("hold_dead", 8'hFF, 7'h7F);
            else              chk("hold_ones", ~(8'h01 << ((k / 4) % 8)), 7'h79);
        end
        // Release mid-frame: "2" must wait for the next digit 0 slot (k=97)
        hold = 1'b0;
        while (k < 96) begin
            step();
            if ((k % 4) == 0) chk("unhold_dead", 8'hFF, 7'h7F);
            else              chk("unhold_ones", ~(8'h01 << ((k / 4) % 8)), 7'h79);
        end
        step(); chk("new_d0", 8'hFE, 7'h24);
        step_to(101); chk("new_d1", 8'hFD, 7'h24);

        // Reset during digit 5 slot aborts at once and the new value loads on release
        reset_with(32'h1234ABCD);
        step_to(22);
        chk("pre_abort_d5", 8'hDF, 7'h30);
        rst    = 1'b1;
        number = 32'h000000A5;
        step();
        chk("abort_off", 8'hFF, 7'h7F);
        rst = 1'b0;
        k   = -1;
        step(); chk("restart_dead", 8'hFF, 7'h7F);
        step(); chk("restart_d0", 8'hFE, 7'h12);
        step_to(6); chk("restart_d1", 8'hFD, 7'h08);
        step_to(9); chk("restart_d2_blank", 8'hFF, 7'h7F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
